// File: rtl/mrelbp_ci_r6.sv
// mrelbp_ci_r6 -- radius-6 centre-intensity bit of the MRELBP descriptor.
//
// A 13x13 window is streamed in one column per cycle. For every complete
// window the block reports whether the 3x3 median around the centre is at
// least the window mean (169*median >= window sum, so no divider is needed).
//
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous active-high reset, clears all state
//   done_i           column valid; S1..S13 are taken on every edge where high
//   S1..S13          one window column, S1 = top row, unsigned 8-bit
//   done_o           ci_o is valid this cycle
//   ci_o             CI bit, holds its last value while done_o is low
//   progress_done_o  one-cycle end-of-frame pulse
module mrelbp_ci_r6 (
    input  logic       clk,
    input  logic       rst,
    input  logic       done_i,
    input  logic [7:0] S1,
    input  logic [7:0] S2,
    input  logic [7:0] S3,
    input  logic [7:0] S4,
    input  logic [7:0] S5,
    input  logic [7:0] S6,
    input  logic [7:0] S7,
    input  logic [7:0] S8,
    input  logic [7:0] S9,
    input  logic [7:0] S10,
    input  logic [7:0] S11,
    input  logic [7:0] S12,
    input  logic [7:0] S13,
    output logic       done_o,
    output logic       ci_o,
    output logic       progress_done_o
);

    // col_in[r] is row r of the incoming column (r = 0 is S1)
    logic [12:0][7:0]        col_in;
    // col[k][r]: k = 0 newest column, k = 12 oldest
    logic [12:0][12:0][7:0]  col;
    logic [12:0][11:0]       csum;
    logic [11:0]             csum_in;
    logic [15:0]             win_sum;
    logic [3:0]              fill;
    logic                    done_d;
    logic                    eof;
    logic                    win_done;
    logic                    v1;
    logic                    v2;
    logic [7:0]              med;
    logic [7:0]              med_c;
    logic [15:0]             sum2;
    logic [15:0]             prod;
    logic [1:0]              eof_pipe;
    logic [8:0][7:0]         pix;
    logic [3:0]              rank;

    assign col_in   = {S13, S12, S11, S10, S9, S8, S7, S6, S5, S4, S3, S2, S1};
    assign eof      = done_d & ~done_i;
    // counter already at 12 means the incoming column is the 13th or later
    assign win_done = (fill >= 4'd12);
    assign prod     = {8'd0, med} * 16'd169;

    always_comb begin
        csum_in = '0;
        for (int r = 0; r < 13; r++)
            csum_in = csum_in + {4'd0, col_in[r]};
    end

    // 3x3 centre: rows S6..S8 of columns 5..7 in the store
    always_comb begin
        pix = '0;
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 3; r++)
                pix[c*3 + r] = col[5 + c][5 + r];
    end

    // Rank-selection median: each pixel counts how many others sort before
    // it (ties broken by index so ranks are a permutation); rank 4 is the median.
    always_comb begin
        med_c = '0;
        rank  = '0;
        for (int i = 0; i < 9; i++) begin
            rank = '0;
            for (int j = 0; j < 9; j++)
                if ((pix[j] < pix[i]) || ((pix[j] == pix[i]) && (j < i)))
                    rank = rank + 4'd1;
            if (rank == 4'd4)
                med_c = pix[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col             <= '0;
            csum            <= '0;
            win_sum         <= '0;
            fill            <= '0;
            done_d          <= 1'b0;
            v1              <= 1'b0;
            v2              <= 1'b0;
            med             <= '0;
            sum2            <= '0;
            done_o          <= 1'b0;
            ci_o            <= 1'b0;
            eof_pipe        <= '0;
            progress_done_o <= 1'b0;
        end else begin
            done_d <= done_i;
            v1     <= done_i & win_done;
            if (done_i) begin
                col     <= {col[11:0], col_in};
                csum    <= {csum[11:0], csum_in};
                // running sum stays exact because stores start each frame at zero
                win_sum <= win_sum + {4'd0, csum_in} - {4'd0, csum[12]};
                if (fill != 4'd13)
                    fill <= fill + 4'd1;
            end else if (eof) begin
                col     <= '0;
                csum    <= '0;
                win_sum <= '0;
                fill    <= '0;
            end
            // later stages read pre-edge values, so a clear does not disturb them
            med    <= med_c;
            sum2   <= win_sum;
            v2     <= v1;
            done_o <= v2;
            if (v2)
                ci_o <= (prod >= sum2);
            eof_pipe        <= {eof_pipe[0], eof};
            progress_done_o <= eof_pipe[1];
        end
    end

endmodule

// File: tb/tb_mrelbp_ci_r6.sv
module tb_mrelbp_ci_r6;

    logic       clk = 1'b0;
    logic       rst;
    logic       done_i;
    logic [7:0] s [13];
    logic       done_o;
    logic       ci_o;
    logic       progress_done_o;

    mrelbp_ci_r6 dut (
        .clk(clk), .rst(rst), .done_i(done_i),
        .S1(s[0]), .S2(s[1]), .S3(s[2]), .S4(s[3]), .S5(s[4]), .S6(s[5]),
        .S7(s[6]), .S8(s[7]), .S9(s[8]), .S10(s[9]), .S11(s[10]),
        .S12(s[11]), .S13(s[12]),
        .done_o(done_o), .ci_o(ci_o), .progress_done_o(progress_done_o)
    );

    always #5 clk = ~clk;

    // cyc = index of the last rising edge
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // result log, sampled on the falling edge
    int ci_q [$];
    int dq   [$];
    int pq   [$];
    always @(negedge clk) begin
        if (done_o === 1'b1) begin
            ci_q.push_back(int'(ci_o));
            dq.push_back(cyc);
        end
        if (progress_done_o === 1'b1) pq.push_back(cyc);
    end

    int n_cmp = 0;
    int n_err = 0;
    int last_edge;

    task chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // one column per call; last_edge is the edge that will sample it
    task push_col(input logic d, input logic [12:0][7:0] v);
        @(negedge clk);
        done_i = d;
        for (int r = 0; r < 13; r++) s[r] = v[r];
        last_edge = cyc + 1;
    endtask

    task push_u(input logic d, input logic [7:0] v);
        push_col(d, {13{v}});
    endtask

    task idle(input int n);
        for (int i = 0; i < n; i++) push_u(1'b0, 8'd0);
    endtask

    function automatic int rv(input int j);
        if (j <= 15)      return 10 * j;
        else if (j <= 30) return 10 * (j - 14);
        else              return 10 * (j - 28);
    endfunction

    function automatic int med3(input int a, input int b, input int c);
        if ((a >= b && a <= c) || (a <= b && a >= c)) return a;
        if ((b >= a && b <= c) || (b <= a && b >= c)) return b;
        return c;
    endfunction

    initial begin
        int b, bp, e13, e_last, e13r, m, sm, ex;
        logic [12:0][7:0] v;

        rst = 1'b1; done_i = 1'b0;
        for (int r = 0; r < 13; r++) s[r] = 8'd0;
        @(negedge clk);
        chk("rst_done_o", int'(done_o), 0);
        chk("rst_ci_o", int'(ci_o), 0);
        chk("rst_progress", int'(progress_done_o), 0);
        rst = 1'b0;

        // constant image: 20 columns of 100, every window ties -> 1
        b = dq.size(); bp = pq.size();
        for (int j = 1; j <= 20; j++) begin
            push_u(1'b1, 8'd100);
            if (j == 13) e13 = last_edge;
        end
        e_last = last_edge;
        idle(6);
        chk("const_count", dq.size() - b, 8);
        for (int p = 0; p < 8 && b + p < ci_q.size(); p++)
            chk($sformatf("const_ci%0d", p), ci_q[b+p], 1);
        if (dq.size() >= b + 8) begin
            chk("const_first_cyc", dq[b], e13 + 2);
            chk("const_last_cyc", dq[b+7], e_last + 2);
        end
        chk("const_eof_count", pq.size() - bp, 1);
        if (pq.size() > bp) chk("const_eof_cyc", pq[bp], e_last + 3);
        chk("hold_done_o", int'(done_o), 0);
        chk("hold_ci_o", int'(ci_o), 1);

        // dark centre: stream columns 6..8, rows S6..S8 = 0, rest 200
        b = dq.size();
        for (int j = 1; j <= 13; j++) begin
            v = {13{8'd200}};
            if (j >= 6 && j <= 8) begin
                v[5] = 8'd0; v[6] = 8'd0; v[7] = 8'd0;
            end
            push_col(1'b1, v);
        end
        idle(6);
        chk("dark_count", dq.size() - b, 1);
        if (ci_q.size() > b) chk("dark_ci", ci_q[b], 0);

        // ramp of 45 columns, one gap cycle, then a 13-column restart of 50
        b = dq.size(); bp = pq.size();
        for (int j = 1; j <= 45; j++) push_u(1'b1, 8'(rv(j)));
        e_last = last_edge;
        idle(1);
        for (int j = 1; j <= 13; j++) push_u(1'b1, 8'd50);
        e13r = last_edge;
        idle(6);
        chk("ramp_count", dq.size() - b, 34);
        if (dq.size() >= b + 34) begin
            chk("ramp_p1", ci_q[b], 1);
            chk("ramp_p4", ci_q[b+3], 1);
            chk("ramp_p10", ci_q[b+9], 0);
            for (int p = 1; p <= 33; p++) begin
                m  = med3(rv(p+5), rv(p+6), rv(p+7));
                sm = 0;
                for (int k = p; k <= p + 12; k++) sm += 13 * rv(k);
                ex = (169 * m >= sm) ? 1 : 0;
                chk($sformatf("ramp_model_p%0d", p), ci_q[b+p-1], ex);
            end
            chk("ramp_span", dq[b+32] - dq[b], 32);
            chk("ramp_last_cyc", dq[b+32], e_last + 2);
            chk("restart_cyc", dq[b+33], e13r + 2);
            chk("restart_ci", ci_q[b+33], 1);
        end
        chk("ramp_eof_count", pq.size() - bp, 2);
        if (pq.size() >= bp + 2) begin
            chk("ramp_eof_cyc", pq[bp], e_last + 3);
            chk("restart_eof_cyc", pq[bp+1], e13r + 3);
        end

        // mid-frame reset after column 15
        for (int j = 1; j <= 15; j++) push_u(1'b1, 8'd100);
        @(negedge clk);
        chk("mid_done_before", int'(done_o), 1);
        rst = 1'b1; done_i = 1'b0;
        #1;
        chk("mid_done_rst", int'(done_o), 0);
        chk("mid_ci_rst", int'(ci_o), 0);
        @(negedge clk);
        rst = 1'b0;
        b = dq.size(); bp = pq.size();
        for (int j = 1; j <= 13; j++) begin
            push_u(1'b1, 8'd100);
            if (j == 13) e13 = last_edge;
        end
        idle(6);
        chk("mid_count", dq.size() - b, 1);
        if (dq.size() > b) chk("mid_first_cyc", dq[b], e13 + 2);
        chk("mid_eof_count", pq.size() - bp, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
